exec_pipe_ctrl: RTL and testbench

Issue/hazard controller sitting between Decode and the Execute stage of the core. Decides each cycle whether the decoded instruction advances into Execute. Stalls on read-after-write hazards via a write-back scoreboard, and drives fetch flushes on taken branches. Runs the core-level IDLE/RUN/FLUSH/HALT sequence from Execute's registered branch and halt outputs.

---
 rtl/exec_pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_exec_pipe_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exec_pipe_ctrl.sv
// Issue/hazard controller between Decode and Execute: scoreboard-based RAW stalls,
// branch flush sequencing and the core-level IDLE/RUN/FLUSH/HALT state machine.
module exec_pipe_ctrl #(
   parameter int WB_LAT       = 2,   // cycles a register write stays pending, >= 1
   parameter int FLUSH_CYCLES = 2    // bubble cycles after a taken branch, >= 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dec_valid,
   input  logic [3:0] dec_src1,
   input  logic [3:0] dec_src2,
   input  logic       dec_use1,
   input  logic       dec_use2,
   input  logic [3:0] dec_dst,
   input  logic       dec_reg_write,
   input  logic       exe_do_branch,
   input  logic       exe_do_halt,
   output logic       issue,
   output logic       stall,
   output logic       flush,
   output logic       running,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           st;
   logic [CNT_W-1:0] cnt;
   logic             exe_valid;
   logic             sb_v    [WB_LAT];
   logic [3:0]       sb_addr [WB_LAT];
   logic             hazard;
   logic             halt_ev;
   logic             br_ev;

   // Execute powers up with a stale halt flag, so its flags only count behind exe_valid.
   assign halt_ev = exe_valid && exe_do_halt;
   assign br_ev   = exe_valid && exe_do_branch && !exe_do_halt;

   always_comb begin
      // NOTE: default assignment first so no path through the block leaves hazard unassigned (no latch).
      hazard = 1'b0;
      for (int i = 0; i < WB_LAT; i++) begin
         if (sb_v[i] && ((dec_use1 && (sb_addr[i] == dec_src1)) ||
                         (dec_use2 && (sb_addr[i] == dec_src2))))
            hazard = 1'b1;
      end
   end

   assign issue = (st == RUN) && dec_valid && !hazard && !halt_ev && !br_ev;
   assign stall = dec_valid && !issue;
   assign flush = (st == FLUSH) || ((st == RUN) && br_ev);
   assign state = st;

   // Valid bits shift every cycle in every state, so pending writes drain across HALT/FLUSH.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         for (int i = 0; i < WB_LAT; i++) sb_v[i] <= 1'b0;
      end else begin
         sb_v[0] <= issue && dec_reg_write;
         for (int i = 1; i < WB_LAT; i++) sb_v[i] <= sb_v[i-1];
      end
   end

   // NOTE: address fields need no reset; they are only looked at when the matching valid bit is set.
   always_ff @(posedge clk) begin
      sb_addr[0] <= dec_dst;
      for (int i = 1; i < WB_LAT; i++) sb_addr[i] <= sb_addr[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         cnt       <= '0;
         exe_valid <= 1'b0;
         running   <= 1'b0;
      end else begin
         exe_valid <= issue;
         unique case (st)
            IDLE: begin
               if (start) begin
                  st      <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (halt_ev) begin
                  st      <= HALT;
                  running <= 1'b0;
               end else if (br_ev) begin
                  st  <= FLUSH;
                  cnt <= CNT_LOAD;
               end
            end
            FLUSH: begin
               if (cnt == '0) st <= RUN;
               else           cnt <= cnt - CNT_ONE;
            end
            HALT: begin
               if (start) begin
                  st      <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               st      <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_pipe_ctrl.sv
// Bench for exec_pipe_ctrl: directed vector table followed by randomized traffic,
// both checked against a timestamp-based reference model.
module tb_exec_pipe_ctrl;

   localparam int WB_LAT       = 2;
   localparam int FLUSH_CYCLES = 2;
   localparam int N_RAND       = 3000;

   typedef struct packed {
      logic       rst;
      logic       start;
      logic       dv;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       u1;
      logic       u2;
      logic [3:0] dst;
      logic       rw;
      logic       br;
      logic       ht;
      logic       e_issue;
      logic       e_stall;
      logic       e_flush;
      logic [1:0] e_state;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       dec_valid = 1'b0;
   logic [3:0] dec_src1 = '0, dec_src2 = '0, dec_dst = '0;
   logic       dec_use1 = 1'b0, dec_use2 = 1'b0, dec_reg_write = 1'b0;
   logic       exe_do_branch = 1'b0, exe_do_halt = 1'b0;
   logic       issue, stall, flush, running;
   logic [1:0] state;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: cycle timestamps instead of shift registers and counters.
   int m_cyc;
   int m_state;
   int m_run_at;
   bit m_exe_valid;
   int m_last_wr [16];

   vec_t tbl [26];

   exec_pipe_ctrl #(.WB_LAT(WB_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk(clk), .rst(rst), .start(start), .dec_valid(dec_valid),
      .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_use1(dec_use1), .dec_use2(dec_use2),
      .dec_dst(dec_dst), .dec_reg_write(dec_reg_write),
      .exe_do_branch(exe_do_branch), .exe_do_halt(exe_do_halt),
      .issue(issue), .stall(stall), .flush(flush), .running(running), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit r, st, dv, input logic [3:0] s1, s2, input bit u1, u2,
                               input logic [3:0] dst, input bit rw, br, ht,
                               input bit ei, es, ef, input logic [1:0] est);
      vec_t v;
      v = '{rst: r, start: st, dv: dv, s1: s1, s2: s2, u1: u1, u2: u2, dst: dst, rw: rw,
            br: br, ht: ht, e_issue: ei, e_stall: es, e_flush: ef, e_state: est};
      return v;
   endfunction

   function automatic bit pending(input logic [3:0] r);
      int age;
      age = m_cyc - m_last_wr[r];
      return (age >= 1) && (age <= WB_LAT);
   endfunction

   task automatic model_reset();
      m_state     = 0;
      m_exe_valid = 1'b0;
      m_run_at    = 0;
      for (int r = 0; r < 16; r++) m_last_wr[r] = -1000;
   endtask

   // Drive one cycle, compare against the model (and the table row if asked), advance.
   task automatic step(input vec_t v, input bit use_tbl);
      bit hz, hev, bev, ei, es, ef, er;
      rst = v.rst; start = v.start; dec_valid = v.dv;
      dec_src1 = v.s1; dec_src2 = v.s2; dec_use1 = v.u1; dec_use2 = v.u2;
      dec_dst = v.dst; dec_reg_write = v.rw;
      exe_do_branch = v.br; exe_do_halt = v.ht;
      #2;
      hz  = (v.u1 && pending(v.s1)) || (v.u2 && pending(v.s2));
      hev = m_exe_valid && v.ht;
      bev = m_exe_valid && v.br && !v.ht;
      ei  = (m_state == 1) && v.dv && !hz && !hev && !bev;
      es  = v.dv && !ei;
      ef  = (m_state == 2) || ((m_state == 1) && bev);
      er  = (m_state == 1) || (m_state == 2);
      check("issue", 32'(issue), 32'(ei));
      check("stall", 32'(stall), 32'(es));
      check("flush", 32'(flush), 32'(ef));
      check("running", 32'(running), 32'(er));
      check("state", 32'(state), 32'(m_state));
      if (use_tbl) begin
         check("tbl_issue", 32'(issue), 32'(v.e_issue));
         check("tbl_stall", 32'(stall), 32'(v.e_stall));
         check("tbl_flush", 32'(flush), 32'(v.e_flush));
         check("tbl_state", 32'(state), 32'(v.e_state));
      end
      if (v.rst) begin
         model_reset();
      end else begin
         if (ei && v.rw) m_last_wr[v.dst] = m_cyc;
         m_exe_valid = ei;
         case (m_state)
            0: if (v.start) m_state = 1;
            1: begin
               if (hev) m_state = 3;
               else if (bev) begin
                  m_state  = 2;
                  m_run_at = m_cyc + 1 + FLUSH_CYCLES;
               end
            end
            2: if (m_cyc + 1 == m_run_at) m_state = 1;
            default: if (v.start) m_state = 1;
         endcase
      end
      @(posedge clk);
      #1;
      m_cyc++;
   endtask

   initial begin
      vec_t rv;
      // rst,start,dv, s1,s2,u1,u2, dst,rw, br,ht | issue,stall,flush,state
      tbl[0]  = mk(1,0,1, 0,0,0,0, 0,0, 0,0, 0,1,0,0);   // reset with dec_valid held
      tbl[1]  = mk(1,0,1, 0,0,0,0, 0,0, 0,0, 0,1,0,0);
      tbl[2]  = mk(0,1,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0);   // start pulse
      tbl[3]  = mk(0,0,1, 1,2,1,1, 3,1, 0,0, 1,0,0,1);   // write r3 at t
      tbl[4]  = mk(0,0,1, 5,3,1,1, 4,1, 0,0, 0,1,0,1);   // reads r3 via src2
      tbl[5]  = mk(0,0,1, 5,3,1,1, 4,1, 0,0, 0,1,0,1);
      tbl[6]  = mk(0,0,1, 5,3,1,1, 4,1, 0,0, 1,0,0,1);   // issues at t+3
      tbl[7]  = mk(0,0,1, 0,4,0,0, 5,0, 0,0, 1,0,0,1);   // r4 named but not read
      tbl[8]  = mk(0,0,1, 7,0,1,0, 6,0, 0,0, 1,0,0,1);   // branch issued
      tbl[9]  = mk(0,0,1, 0,0,0,0, 0,0, 1,0, 0,1,1,1);
      tbl[10] = mk(0,0,1, 0,0,0,0, 0,0, 1,0, 0,1,1,2);   // stale branch flag ignored
      tbl[11] = mk(0,0,1, 0,0,0,0, 0,0, 0,0, 0,1,1,2);
      tbl[12] = mk(0,0,1, 0,0,0,0, 0,0, 0,0, 1,0,0,1);   // resumes, issues halt+branch
      tbl[13] = mk(0,0,1, 0,0,0,0, 0,0, 1,1, 0,1,0,1);   // halt wins, no flush
      tbl[14] = mk(0,0,1, 0,0,0,0, 0,0, 0,0, 0,1,0,3);
      tbl[15] = mk(0,1,1, 0,0,0,0, 0,0, 0,0, 0,1,0,3);
      tbl[16] = mk(0,0,1, 0,0,0,0, 0,0, 0,0, 1,0,0,1);
      tbl[17] = mk(1,0,0, 0,0,0,0, 0,0, 0,1, 0,0,0,1);   // reset with halt held
      tbl[18] = mk(0,1,0, 0,0,0,0, 0,0, 0,1, 0,0,0,0);
      tbl[19] = mk(0,0,1, 0,0,0,0, 0,0, 0,1, 1,0,0,1);   // stale halt ignored
      tbl[20] = mk(0,0,1, 0,0,0,0, 0,0, 0,0, 1,0,0,1);
      tbl[21] = mk(0,0,1, 0,0,0,0, 9,1, 0,0, 1,0,0,1);   // branch writing r9
      tbl[22] = mk(0,0,1, 0,0,0,0, 0,0, 1,0, 0,1,1,1);
      tbl[23] = mk(1,0,1, 0,0,0,0, 0,0, 0,0, 0,1,1,2);   // reset mid-flush
      tbl[24] = mk(0,1,1, 9,9,1,1, 0,0, 0,0, 0,1,0,0);
      tbl[25] = mk(0,0,1, 9,9,1,1, 0,0, 0,0, 1,0,0,1);

      m_cyc = 0;
      model_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < 26; i++) step(tbl[i], 1'b1);

      for (int n = 0; n < N_RAND; n++) begin
         rv       = '0;
         rv.rst   = ($urandom_range(0, 99) == 0);
         rv.start = ($urandom_range(0, 7) == 0);
         rv.dv    = ($urandom_range(0, 3) != 0);
         rv.s1    = 4'($urandom_range(0, 3));
         rv.s2    = 4'($urandom_range(0, 3));
         rv.u1    = 1'($urandom_range(0, 1));
         rv.u2    = 1'($urandom_range(0, 1));
         rv.dst   = 4'($urandom_range(0, 3));
         rv.rw    = 1'($urandom_range(0, 1));
         rv.br    = ($urandom_range(0, 4) == 0);
         rv.ht    = ($urandom_range(0, 11) == 0);
         step(rv, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
